// File: rtl/spi_master_arbiter.sv
// spi_master_arbiter
//   Shares one SPI master between NUM_REQ requesters. Requesters are served in
//   round-robin order. Each transaction walks IDLE -> SETUP -> ACTIVE -> HOLD:
//   the owner's chip select drops, the master is enabled after CS_SETUP cycles,
//   completion is detected when the master reports the requested byte count,
//   and CS stays low for CS_HOLD more cycles so the master can finish its
//   byte boundary. An ACTIVE phase longer than TIMEOUT cycles is aborted and
//   reported as an error.
//
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   req_i            per-requester request, held until done_o
//   req_wdata_i      write word, requester k at [32k+:32]
//   req_bytes_i      byte count 1..4, requester k at [3k+:3]
//   grant_o          one-hot current owner
//   done_o / err_o   one-cycle completion / error pulses per requester
//   rdata_o          read word, valid with done_o
//   cs_n_o           active-low chip selects
//   spi_enable_o     master enable
//   spi_wdata_o      master write word
//   spi_bytes_o      master write byte count
//   spi_rdata_i      master read word
//   spi_rbytes_i     master read byte count
module spi_master_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int CS_SETUP = 4,
   parameter int CS_HOLD  = 16,
   parameter int TIMEOUT  = 4096
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [NUM_REQ-1:0]     req_i,
   input  logic [32*NUM_REQ-1:0]  req_wdata_i,
   input  logic [3*NUM_REQ-1:0]   req_bytes_i,
   output logic [NUM_REQ-1:0]     grant_o,
   output logic [NUM_REQ-1:0]     done_o,
   output logic [NUM_REQ-1:0]     err_o,
   output logic [31:0]            rdata_o,
   output logic [NUM_REQ-1:0]     cs_n_o,
   output logic                   spi_enable_o,
   output logic [31:0]            spi_wdata_o,
   output logic [2:0]             spi_bytes_o,
   input  logic [31:0]            spi_rdata_i,
   input  logic [2:0]             spi_rbytes_i
);

   localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int MAX_AB  = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
   localparam int CNT_MAX = (TIMEOUT > MAX_AB) ? TIMEOUT : MAX_AB;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(CS_HOLD - 1);
   localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(CNT_MAX);

   typedef enum logic [1:0] {IDLE, SETUP, ACTIVE, HOLD} state_t;

   state_t                 state, state_n;
   logic [CNT_W-1:0]       cnt, cnt_n;
   logic [IDX_W-1:0]       owner, owner_n;
   logic [IDX_W-1:0]       rr_ptr, rr_ptr_n;
   logic                   timed_out, timed_out_n;

   logic [NUM_REQ-1:0]     grant_n, done_n, err_n, cs_n_n;
   logic [31:0]            rdata_n, wdata_n;
   logic [2:0]             bytes_n;
   logic                   enable_n;

   logic                   pick_valid;
   logic [IDX_W-1:0]       pick_idx;
   logic [2:0]             pick_bytes;
   logic [31:0]            pick_wdata;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
      if (idx == IDX_W'(NUM_REQ - 1)) return '0;
      return idx + IDX_W'(1);
   endfunction

   function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
      if (c == CNT_SAT) return c;
      return c + CNT_W'(1);
   endfunction

   // First requester at or after rr_ptr, wrapping around.
   always_comb begin
      int idx;
      idx        = 0;
      pick_valid = 1'b0;
      pick_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!pick_valid && req_i[idx]) begin
            pick_valid = 1'b1;
            pick_idx   = IDX_W'(idx);
         end
      end
      pick_bytes = req_bytes_i[3*int'(pick_idx) +: 3];
      pick_wdata = req_wdata_i[32*int'(pick_idx) +: 32];
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      owner_n     = owner;
      rr_ptr_n    = rr_ptr;
      timed_out_n = timed_out;
      grant_n     = grant_o;
      done_n      = '0;
      err_n       = '0;
      cs_n_n      = cs_n_o;
      rdata_n     = rdata_o;
      wdata_n     = spi_wdata_o;
      bytes_n     = spi_bytes_o;
      enable_n    = spi_enable_o;

      unique case (state)
         IDLE: begin
            if (pick_valid) begin
               if (pick_bytes >= 3'd1 && pick_bytes <= 3'd4) begin
                  state_n     = SETUP;
                  cnt_n       = '0;
                  owner_n     = pick_idx;
                  timed_out_n = 1'b0;
                  grant_n     = onehot(pick_idx);
                  cs_n_n      = ~onehot(pick_idx);
                  wdata_n     = pick_wdata;
                  bytes_n     = pick_bytes;
               end else begin
                  // Bad byte count: reject without touching CS, move the pointer on.
                  err_n    = onehot(pick_idx);
                  rr_ptr_n = next_idx(pick_idx);
               end
            end
         end
         SETUP: begin
            if (cnt == SETUP_LAST) begin
               state_n  = ACTIVE;
               cnt_n    = '0;
               enable_n = 1'b1;
            end else begin
               cnt_n = cnt_inc(cnt);
            end
         end
         ACTIVE: begin
            if (spi_rbytes_i == spi_bytes_o) begin
               state_n  = HOLD;
               cnt_n    = '0;
               enable_n = 1'b0;
               rdata_n  = spi_rdata_i;
            end else if (cnt == TO_LAST) begin
               state_n     = HOLD;
               cnt_n       = '0;
               enable_n    = 1'b0;
               timed_out_n = 1'b1;
            end else begin
               cnt_n = cnt_inc(cnt);
            end
         end
         HOLD: begin
            if (cnt == HOLD_LAST) begin
               state_n  = IDLE;
               cnt_n    = '0;
               cs_n_n   = '1;
               grant_n  = '0;
               rr_ptr_n = next_idx(owner);
               if (timed_out) err_n  = onehot(owner);
               else           done_n = onehot(owner);
            end else begin
               cnt_n = cnt_inc(cnt);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= IDLE;
         cnt          <= '0;
         owner        <= '0;
         rr_ptr       <= '0;
         timed_out    <= 1'b0;
         grant_o      <= '0;
         done_o       <= '0;
         err_o        <= '0;
         cs_n_o       <= '1;
         rdata_o      <= '0;
         spi_wdata_o  <= '0;
         spi_bytes_o  <= '0;
         spi_enable_o <= 1'b0;
      end else begin
         state        <= state_n;
         cnt          <= cnt_n;
         owner        <= owner_n;
         rr_ptr       <= rr_ptr_n;
         timed_out    <= timed_out_n;
         grant_o      <= grant_n;
         done_o       <= done_n;
         err_o        <= err_n;
         cs_n_o       <= cs_n_n;
         rdata_o      <= rdata_n;
         spi_wdata_o  <= wdata_n;
         spi_bytes_o  <= bytes_n;
         spi_enable_o <= enable_n;
      end
   end

endmodule

// File: tb/tb_spi_master_arbiter.sv
// tb_spi_master_arbiter
//   Directed bench for spi_master_arbiter (NUM_REQ=4, CS_SETUP=4, CS_HOLD=16,
//   TIMEOUT=4096). A small slave model reports the latched byte count eight
//   cycles after enable rises, unless told to stay silent.
module tb_spi_master_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [127:0] req_wdata;
   logic [11:0] req_bytes;
   logic [3:0]  grant, done, err, cs_n;
   logic [31:0] rdata, spi_wdata, spi_rdata;
   logic        spi_enable;
   logic [2:0]  spi_bytes, spi_rbytes;

   int checks = 0;
   int errors = 0;
   int viol   = 0;
   int n;

   logic [31:0] slave_data = '0;
   logic        stuck = 1'b0;
   int          en_cnt = 0;

   logic        rec_en = 1'b0;
   logic [3:0]  prev_grant = '0;
   logic [3:0]  grant_q[$];
   logic [3:0]  exp_g [5];

   always #5 clk = ~clk;

   spi_master_arbiter #(
      .NUM_REQ(4), .CS_SETUP(4), .CS_HOLD(16), .TIMEOUT(4096)
   ) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .req_wdata_i(req_wdata),
      .req_bytes_i(req_bytes), .grant_o(grant), .done_o(done), .err_o(err),
      .rdata_o(rdata), .cs_n_o(cs_n), .spi_enable_o(spi_enable),
      .spi_wdata_o(spi_wdata), .spi_bytes_o(spi_bytes),
      .spi_rdata_i(spi_rdata), .spi_rbytes_i(spi_rbytes)
   );

   // Slave model
   initial begin
      spi_rbytes = '0;
      spi_rdata  = '0;
      forever begin
         @(negedge clk);
         if (spi_enable) begin
            en_cnt = en_cnt + 1;
            if (en_cnt >= 8 && !stuck) begin
               spi_rbytes = spi_bytes;
               spi_rdata  = slave_data;
            end
         end else begin
            en_cnt     = 0;
            spi_rbytes = '0;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      if ($countones(~cs_n) > 1) viol++;
      if ($countones(grant) > 1) viol++;
      if (spi_enable && (cs_n == 4'hF)) viol++;
      if (rec_en && grant != 4'h0 && prev_grant == 4'h0) grant_q.push_back(grant);
      prev_grant = grant;
   endtask

   task automatic wait_event(input int limit, output int cyc);
      cyc = -1;
      for (int i = 1; i <= limit; i++) begin
         tick();
         if ((done | err) != 4'h0) begin
            cyc = i;
            break;
         end
      end
   endtask

   task automatic wait_enable(input int limit);
      for (int i = 0; i < limit; i++) begin
         if (spi_enable) break;
         tick();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      req       = '0;
      req_wdata = '0;
      req_bytes = '0;
      exp_g     = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      do_reset();

      // Reset state
      check("rst_grant", 32'(grant), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_cs", 32'(cs_n), 32'hF);
      check("rst_en", 32'(spi_enable), 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_wbytes", {spi_wdata[28:0], spi_bytes}, 32'h0);

      // Single request on requester 1
      slave_data = 32'h0000003C;
      req_wdata[63:32] = 32'h0000A55A;
      req_bytes = 12'b001_001_010_001;
      req = 4'b0010;
      tick();
      check("t1_grant", 32'(grant), 32'h2);
      check("t1_cs", 32'(cs_n), 32'hD);
      check("t1_wdata", spi_wdata, 32'h0000A55A);
      check("t1_bytes", 32'(spi_bytes), 32'h2);
      tick(); tick(); tick();
      check("t1_en_early", 32'(spi_enable), 32'h0);
      tick();
      check("t1_en", 32'(spi_enable), 32'h1);
      check("t1_cs_active", 32'(cs_n), 32'hD);
      wait_event(100, n);
      check("t1_latency", 32'(n), 32'd24);
      check("t1_done", 32'(done), 32'h2);
      check("t1_rdata", 32'(rdata[15:0]), 32'h3C);
      check("t1_cs_end", 32'(cs_n), 32'hF);
      req = '0;
      tick();
      check("t1_done_pulse", 32'(done), 32'h0);

      // Round robin with all requests held
      do_reset();
      req_bytes = 12'b001_001_001_001;
      req = 4'b1111;
      rec_en = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (grant_q.size() >= 5) break;
         tick();
      end
      rec_en = 1'b0;
      req = '0;
      check("rr_count", 32'(grant_q.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         check($sformatf("rr_grant%0d", i), 32'((i < grant_q.size()) ? grant_q[i] : 4'h0), 32'(exp_g[i]));
      wait_event(60, n);
      tick();

      // Bad byte counts on requester 2
      do_reset();
      req_bytes = 12'b001_000_001_001;
      req = 4'b0100;
      tick();
      check("e0_err", 32'(err), 32'h4);
      check("e0_cs", 32'(cs_n), 32'hF);
      check("e0_grant", 32'(grant), 32'h0);
      req = '0;
      tick();
      check("e0_err_pulse", 32'(err), 32'h0);
      req_bytes = 12'b001_101_001_001;
      req = 4'b0100;
      tick();
      check("e5_err", 32'(err), 32'h4);
      req = '0;
      tick();
      // Pointer now at 3: requester 3 wins over requester 0
      req = 4'b1001;
      tick();
      check("e_rr_grant3", 32'(grant), 32'h8);
      check("e_rr_cs3", 32'(cs_n), 32'h7);
      wait_event(60, n);
      check("e_rr_done3", 32'(done), 32'h8);
      req = 4'b0001;
      tick();
      check("e_rr_grant0", 32'(grant), 32'h1);
      wait_event(60, n);
      check("e_rr_done0", 32'(done), 32'h1);
      req = '0;
      tick();

      // Timeout with a silent slave
      do_reset();
      stuck = 1'b1;
      req_bytes = 12'b001_001_001_100;
      req = 4'b0001;
      tick();
      check("to_grant", 32'(grant), 32'h1);
      wait_event(5000, n);
      check("to_latency", 32'(n), 32'd4116);
      check("to_err", 32'(err), 32'h1);
      check("to_done", 32'(done), 32'h0);
      check("to_cs", 32'(cs_n), 32'hF);
      check("to_en", 32'(spi_enable), 32'h0);
      check("to_rdata", rdata, 32'h0);
      req = '0;
      stuck = 1'b0;
      tick();

      // Reset in ACTIVE
      req_bytes = 12'b001_001_010_001;
      req = 4'b0010;
      tick();
      wait_enable(10);
      check("ra_en", 32'(spi_enable), 32'h1);
      rst = 1'b1;
      req = '0;
      tick();
      check("ra_en_off", 32'(spi_enable), 32'h0);
      check("ra_cs", 32'(cs_n), 32'hF);
      check("ra_grant", 32'(grant), 32'h0);
      rst = 1'b0;
      tick();

      // Request dropped during ACTIVE
      slave_data = 32'h12345678;
      req_bytes = 12'b001_001_001_100;
      req = 4'b0001;
      tick();
      wait_enable(10);
      check("dr_en", 32'(spi_enable), 32'h1);
      req = '0;
      wait_event(60, n);
      check("dr_latency", 32'(n), 32'd24);
      check("dr_done", 32'(done), 32'h1);
      check("dr_rdata", rdata, 32'h12345678);
      tick();

      check("invariants", 32'(viol), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
